// File: rtl/rca_pkg.sv
// -----------------------------------------------------------------------------
// rca_pkg
// Shared definitions for the hybrid rule-90/150 cellular-automaton random
// generator.
//   RCA_MAX_WIDTH         widest state that the ca_next helper can handle
//   RCA_DEFAULT_WIDTH     default cell count
//   RCA_DEFAULT_RULE_MASK default per-cell rule select (only cell 0 uses rule 150)
//   RCA_ZERO_GUARD_STATE  state that replaces all-zero when the zero guard is
//                         enabled (RCA_SEED_ZERO_GUARD_EN)
//   ca_next()             computes one CA generation with null boundaries
// -----------------------------------------------------------------------------
package rca_pkg;

    localparam int RCA_MAX_WIDTH     = 64;
    localparam int RCA_DEFAULT_WIDTH = 32;

    localparam logic [RCA_MAX_WIDTH-1:0] RCA_DEFAULT_RULE_MASK = 64'd1;
    localparam logic [RCA_MAX_WIDTH-1:0] RCA_ZERO_GUARD_STATE  = 64'd1;

    // One generation: cell i takes left ^ right, plus itself when its rule bit
    // selects rule 150. Cells outside the array read as 0.
    function automatic logic [RCA_MAX_WIDTH-1:0] ca_next(
        input logic [RCA_MAX_WIDTH-1:0] state,
        input logic [RCA_MAX_WIDTH-1:0] mask,
        input int                       width
    );
        logic [RCA_MAX_WIDTH-1:0] nxt;
        logic                     lft;
        logic                     rgt;
        nxt = '0;
        for (int i = 0; i < RCA_MAX_WIDTH; i++) begin
            if (i < width) begin
                lft    = (i + 1 < width) ? state[i+1] : 1'b0;
                rgt    = (i > 0) ? state[i-1] : 1'b0;
                nxt[i] = lft ^ rgt ^ (mask[i] & state[i]);
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rca_cell.sv
// -----------------------------------------------------------------------------
// rca_cell
// One cell of the cellular automaton.
//   clk        rising-edge clock
//   rst        synchronous active-low load: cell takes seed_bit
//   ce         advance one generation when high
//   seed_bit   value loaded while rst is low
//   left_bit   state of the neighbour at index i+1 (0 at the boundary)
//   right_bit  state of the neighbour at index i-1 (0 at the boundary)
//   rule_bit   1 = rule 150 (include own state), 0 = rule 90
//   q          registered cell state
// -----------------------------------------------------------------------------
module rca_cell (
    input  logic clk,
    input  logic rst,
    input  logic ce,
    input  logic seed_bit,
    input  logic left_bit,
    input  logic right_bit,
    input  logic rule_bit,
    output logic q
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = left_bit ^ right_bit ^ (rule_bit & q_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            q_q <= seed_bit;
        end else if (ce) begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/randomic_cellular_automata_based.sv
// -----------------------------------------------------------------------------
// randomic_cellular_automata_based
// Pseudo-random word generator built from a 1-D hybrid rule-90/150 cellular
// automaton. One generation per enabled clock; the CA state is the output.
//   clk     rising-edge clock
//   rst     synchronous active-low reset, loads seed (priority over ce)
//   ce      advance one generation per cycle when high
//   seed    initial CA state, sampled only while rst is low
//   random  current CA state (registered)
// Optional feature macro: RCA_SEED_ZERO_GUARD_EN
//   When defined, an all-zero seed loads 1 instead, and an all-zero state is
//   replaced by 1 on the next enabled edge, so the output never sticks at 0.
// -----------------------------------------------------------------------------
module randomic_cellular_automata_based
    import rca_pkg::*;
#(
    parameter int               Width    = RCA_DEFAULT_WIDTH,
    parameter logic [Width-1:0] RuleMask = {{(Width-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [Width-1:0] seed,
    output logic [Width-1:0] random
);

    // Cell states; each bit is driven by the register inside its rca_cell.
    logic [Width-1:0] s_q;

    // Cell load control: load_n low makes every cell take load_val.
    logic             load_n;
    logic [Width-1:0] load_val;

`ifdef RCA_SEED_ZERO_GUARD_EN
    localparam logic [Width-1:0] ZeroGuard = Width'(RCA_ZERO_GUARD_STATE);

    logic s_zero;
    logic seed_zero;

    always_comb begin
        s_zero    = (s_q == '0);
        seed_zero = (seed == '0);
        // Reset always loads; while running, an enabled step out of the
        // all-zero fixed point is turned into a load of the guard state.
        load_n    = rst & ~(ce & s_zero);
        load_val  = ZeroGuard;
        if (!rst && !seed_zero) begin
            load_val = seed;
        end
    end
`else
    always_comb begin
        load_n   = rst;
        load_val = seed;
    end
`endif

    for (genvar gi = 0; gi < Width; gi++) begin : g_cell
        logic left_b;
        logic right_b;

        // Null boundary: neighbours beyond either end read as 0.
        if (gi == Width - 1) begin : g_left_edge
            assign left_b = 1'b0;
        end else begin : g_left_inner
            assign left_b = s_q[gi+1];
        end

        if (gi == 0) begin : g_right_edge
            assign right_b = 1'b0;
        end else begin : g_right_inner
            assign right_b = s_q[gi-1];
        end

        rca_cell u_cell (
            .clk       (clk),
            .rst       (load_n),
            .ce        (ce),
            .seed_bit  (load_val[gi]),
            .left_bit  (left_b),
            .right_bit (right_b),
            .rule_bit  (RuleMask[gi]),
            .q         (s_q[gi])
        );
    end

    assign random = s_q;

endmodule

// File: tb/tb_randomic_cellular_automata_based.sv
// -----------------------------------------------------------------------------
// tb_randomic_cellular_automata_based
// Self-checking bench for a 4-cell instance (rule mask 0001) and a 32-cell
// instance (default rule mask). Stimulus pushes expected outputs into
// per-instance queues; a monitor pops and compares one entry per clock.
// Honours RCA_SEED_ZERO_GUARD_EN so the same bench covers both builds.
// -----------------------------------------------------------------------------
module tb_randomic_cellular_automata_based;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst4;
    logic        ce4;
    logic [3:0]  seed4;
    logic [3:0]  rnd4;
    logic        rst32;
    logic        ce32;
    logic [31:0] seed32;
    logic [31:0] rnd32;

    randomic_cellular_automata_based #(
        .Width    (4),
        .RuleMask (4'b0001)
    ) dut4 (
        .clk    (clk),
        .rst    (rst4),
        .ce     (ce4),
        .seed   (seed4),
        .random (rnd4)
    );

    randomic_cellular_automata_based #(
        .Width (32)
    ) dut32 (
        .clk    (clk),
        .rst    (rst32),
        .ce     (ce32),
        .seed   (seed32),
        .random (rnd32)
    );

    typedef struct {
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t q4[$];
    exp_t q32[$];

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0]  m4;
    logic [31:0] m32;

`ifdef RCA_SEED_ZERO_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    // Reference: left neighbour arrives by shifting right, right neighbour by
    // shifting left; rule-150 cells also fold in their own value.
    function automatic logic [31:0] ref_next(input logic [31:0] s, input logic [31:0] mask,
                                             input int w);
        logic [31:0] wm;
        logic [31:0] n;
        wm = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        n  = ((s >> 1) ^ (s << 1) ^ (s & mask)) & wm;
        if (GUARD && s == 32'd0) n = 32'd1;
        return n;
    endfunction

    function automatic logic [31:0] ref_seed(input logic [31:0] sd);
        if (GUARD && sd == 32'd0) return 32'd1;
        return sd;
    endfunction

    // Drive one cycle of the 4-cell instance. use_k selects a literal
    // expectation instead of the model value; the model is tracked either way.
    task automatic drive4(input logic r, input logic c, input logic [3:0] sd,
                          input bit use_k, input logic [3:0] k, input string nm);
        exp_t        e;
        logic [31:0] t;
        @(negedge clk);
        rst4  = r;
        ce4   = c;
        seed4 = sd;
        if (!r) begin
            t  = ref_seed({28'd0, sd});
            m4 = t[3:0];
        end else if (c) begin
            t  = ref_next({28'd0, m4}, 32'h0000_0001, 4);
            m4 = t[3:0];
        end
        e.exp  = use_k ? {28'd0, k} : {28'd0, m4};
        e.name = nm;
        q4.push_back(e);
    endtask

    task automatic drive32(input logic r, input logic c, input logic [31:0] sd,
                           input string nm);
        exp_t e;
        @(negedge clk);
        rst32  = r;
        ce32   = c;
        seed32 = sd;
        if (!r)     m32 = ref_seed(sd);
        else if (c) m32 = ref_next(m32, 32'h0000_0001, 32);
        e.exp  = m32;
        e.name = nm;
        q32.push_back(e);
    endtask

    // Monitor: one comparison per queued expectation, #1 after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q4.size() > 0) begin
            e = q4.pop_front();
            n_checks++;
            if (rnd4 !== e.exp[3:0]) begin
                n_fail++;
                $display("FAIL %s: dut4 random=%b expected=%b", e.name, rnd4, e.exp[3:0]);
            end else begin
                $display("ok   %s: dut4 random=%b", e.name, rnd4);
            end
        end
        if (q32.size() > 0) begin
            e = q32.pop_front();
            n_checks++;
            if (rnd32 !== e.exp) begin
                n_fail++;
                $display("FAIL %s: dut32 random=%h expected=%h", e.name, rnd32, e.exp);
            end else begin
                $display("ok   %s: dut32 random=%h", e.name, rnd32);
            end
        end
    end

    initial begin
        rst4   = 1'b0;
        ce4    = 1'b0;
        seed4  = 4'd0;
        rst32  = 1'b0;
        ce32   = 1'b0;
        seed32 = 32'd0;
        m4     = 4'd0;
        m32    = 32'd0;

        // Reset load and first generations; seed wiggles while running.
        drive4(1'b0, 1'b1, 4'b0001, 1'b1, 4'b0001, "t1_reset_load");
        drive4(1'b1, 1'b1, 4'($urandom), 1'b1, 4'b0011, "t1_gen1");
        drive4(1'b1, 1'b1, 4'($urandom), 1'b1, 4'b0110, "t1_gen2");
        drive4(1'b1, 1'b1, 4'($urandom), 1'b1, 4'b1111, "t1_gen3");

        // Mid-run reset beats ce in both polarities, then run resumes.
        drive4(1'b0, 1'b0, 4'b1010, 1'b1, 4'b1010, "t3_rst_ce0");
        drive4(1'b0, 1'b1, 4'b1010, 1'b1, 4'b1010, "t3_rst_ce1");
        drive4(1'b1, 1'b1, 4'($urandom), 1'b1, 4'b0001, "t3_run1");
        drive4(1'b1, 1'b1, 4'($urandom), 1'b1, 4'b0011, "t3_run2");

        // Hold with ce low, then resume.
        for (int i = 0; i < 5; i++) begin
            drive4(1'b1, 1'b0, 4'($urandom), 1'b1, 4'b0011, "t2_hold");
        end
        drive4(1'b1, 1'b1, 4'($urandom), 1'b1, 4'b0110, "t2_resume");
        drive4(1'b1, 1'b1, 4'($urandom), 1'b1, 4'b1111, "t4_run_a");
        drive4(1'b1, 1'b1, 4'($urandom), 1'b1, 4'b1000, "t4_run_b");
        drive4(1'b1, 1'b1, 4'($urandom), 1'b1, 4'b0100, "t4_run_c");
        drive4(1'b1, 1'b1, 4'($urandom), 1'b1, 4'b1010, "t4_run_d");

        // Held reset reloads seed every cycle.
        drive4(1'b0, 1'b1, 4'b0110, 1'b1, 4'b0110, "held_rst_a");
        drive4(1'b0, 1'b1, 4'b1001, 1'b1, 4'b1001, "held_rst_b");

        // Zero seed: fixed point, or guarded start at 1.
        if (GUARD) begin
            drive4(1'b0, 1'b1, 4'b0000, 1'b1, 4'b0001, "t5_zero_seed_guard");
            drive4(1'b1, 1'b1, 4'($urandom), 1'b1, 4'b0011, "t5_guard_gen1");
            drive4(1'b1, 1'b1, 4'($urandom), 1'b1, 4'b0110, "t5_guard_gen2");
            for (int i = 0; i < 8; i++) begin
                drive4(1'b1, 1'b1, 4'($urandom), 1'b0, 4'b0000, "t5_guard_run");
            end
        end else begin
            drive4(1'b0, 1'b1, 4'b0000, 1'b1, 4'b0000, "t5_zero_seed");
            for (int i = 0; i < 10; i++) begin
                drive4(1'b1, 1'b1, 4'($urandom), 1'b1, 4'b0000, "t5_zero_stuck");
            end
        end

        // Randomised run of the small instance against the model.
        for (int i = 0; i < 400; i++) begin
            drive4(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0),
                   4'($urandom), 1'b0, 4'b0000, "rand4");
        end
        drive4(1'b1, 1'b0, 4'd0, 1'b0, 4'b0000, "rand4_idle");

        // 32-cell instance: random seed, 5000 enabled edges, then mixed traffic.
        drive32(1'b0, 1'b1, $urandom, "t6_reset");
        for (int i = 0; i < 5000; i++) begin
            drive32(1'b1, 1'b1, $urandom, "t6_run");
        end
        for (int i = 0; i < 300; i++) begin
            drive32(($urandom_range(0, 29) != 0), ($urandom_range(0, 3) != 0),
                    (($urandom_range(0, 9) == 0) ? 32'd0 : $urandom), "rand32");
        end

        // Every pushed expectation must have been consumed.
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (q4.size() != 0 || q32.size() != 0) begin
            n_fail++;
            $display("FAIL drain: pending q4=%0d q32=%0d expected 0", q4.size(), q32.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
